// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morse_pkg
// Description : Shared types, symbol encodings, threshold defaults and the
//               unit-length helper for the Morse key decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS     = 2'd1,
        GAP       = 2'd2,
        WORD_WAIT = 2'd3
    } state_e;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int DEF_MAX_SYM      = 6;
    localparam int DEF_DASH_UNITS   = 2;
    localparam int DEF_LETTER_UNITS = 3;
    localparam int DEF_WORD_UNITS   = 7;

    // Speed code 0 is slowest: unit = base * 8, code 7 gives unit = base.
    function automatic logic [15:0] unit_ms(input int unsigned base, input logic [2:0] sel);
        return 16'(base * (32'd8 - 32'(sel)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : morse_tick_gen
// Description : 1 ms tick generator (one pulse every TICK_DIV clocks) with a
//               synchronous clear used to re-phase the tick on key edges.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_tick_gen #(
    parameter int TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/morse_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : morse_key_decoder
// Description : Times key presses/gaps in Morse units, assembles letters and
//               emits letter/space tokens over a valid/ready handshake.
//               Optional macro MORSE_DEBOUNCE_EN adds a 5 ms stability filter.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_DIV     = CLK_HZ / 1000,
    parameter int UNIT_BASE_MS = 20,
    parameter int MAX_SYM      = DEF_MAX_SYM,
    parameter int DASH_UNITS   = DEF_DASH_UNITS,
    parameter int LETTER_UNITS = DEF_LETTER_UNITS,
    parameter int WORD_UNITS   = DEF_WORD_UNITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           key,
    input  logic [2:0]                     speed_sel,
    input  logic                           is_active,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [MAX_SYM-1:0]             out_pattern,
    output logic [$clog2(MAX_SYM+1)-1:0]   out_len,
    output logic                           out_space,
    output logic                           out_err,
    output logic                           ovf,
    output logic                           key_led
);

    localparam int LW = $clog2(MAX_SYM + 1);

    logic r_key_meta, r_key_sync, r_key_d;
    logic w_key, w_rise, w_fall, w_edge, w_tick, w_unit_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_meta <= 1'b0;
            r_key_sync <= 1'b0;
        end else begin
            r_key_meta <= key;
            r_key_sync <= r_key_meta;
        end
    end

    assign key_led = r_key_sync;

`ifdef MORSE_DEBOUNCE_EN
    logic       r_key_flt;
    logic [2:0] r_db_cnt;

    // A level change is accepted only after 5 consecutive ticks of disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_flt <= 1'b0;
            r_db_cnt  <= 3'd0;
        end else if (r_key_sync == r_key_flt) begin
            r_db_cnt <= 3'd0;
        end else if (w_tick) begin
            if (r_db_cnt == 3'd4) begin
                r_key_flt <= r_key_sync;
                r_db_cnt  <= 3'd0;
            end else begin
                r_db_cnt <= r_db_cnt + 3'd1;
            end
        end
    end

    assign w_key = r_key_flt;
`else
    assign w_key = r_key_sync;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_key_d <= 1'b0;
        else     r_key_d <= w_key;
    end

    assign w_rise = w_key & ~r_key_d;
    assign w_fall = ~w_key & r_key_d;
    assign w_edge = w_key ^ r_key_d;

    morse_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_edge),
        .tick (w_tick)
    );

    // Duration measurement: ms within the current unit, and whole units since the last edge.
    logic [15:0] r_unit_ms, r_ms;
    logic [3:0]  r_units;

    assign w_unit_tick = w_tick && (r_ms == r_unit_ms - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_unit_ms <= 16'd0;
            r_ms      <= 16'd0;
            r_units   <= 4'd0;
        end else begin
            if (w_rise) r_unit_ms <= unit_ms(UNIT_BASE_MS, speed_sel);
            if (w_edge) begin
                r_ms    <= 16'd0;
                r_units <= 4'd0;
            end else if (w_tick) begin
                if (w_unit_tick) begin
                    r_ms <= 16'd0;
                    if (r_units != 4'd15) r_units <= r_units + 4'd1;
                end else begin
                    r_ms <= r_ms + 16'd1;
                end
            end
        end
    end

    state_e r_state, w_state_next;
    logic   w_append, w_emit_letter, w_emit_space;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // A threshold tick coinciding with a rising key still emits, then follows the key.
    always_comb begin
        w_state_next  = r_state;
        w_append      = 1'b0;
        w_emit_letter = 1'b0;
        w_emit_space  = 1'b0;
        if (!is_active) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) w_state_next = PRESS;
                end
                PRESS: begin
                    if (w_fall) begin
                        w_append     = 1'b1;
                        w_state_next = GAP;
                    end
                end
                GAP: begin
                    if (w_unit_tick && r_units == 4'(LETTER_UNITS - 1)) begin
                        w_emit_letter = 1'b1;
                        w_state_next  = w_rise ? PRESS : WORD_WAIT;
                    end else if (w_rise) begin
                        w_state_next = PRESS;
                    end
                end
                WORD_WAIT: begin
                    if (w_unit_tick && r_units == 4'(WORD_UNITS - 1)) begin
                        w_emit_space = 1'b1;
                        w_state_next = w_rise ? PRESS : IDLE;
                    end else if (w_rise) begin
                        w_state_next = PRESS;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    logic [MAX_SYM-1:0] r_pattern;
    logic [LW-1:0]      r_len;
    logic               r_err_pend;
    logic               w_sym;

    assign w_sym = (r_units >= 4'(DASH_UNITS)) ? SYM_DASH : SYM_DOT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern  <= '0;
            r_len      <= '0;
            r_err_pend <= 1'b0;
        end else if (!is_active || w_emit_letter) begin
            r_pattern  <= '0;
            r_len      <= '0;
            r_err_pend <= 1'b0;
        end else if (w_append) begin
            if (r_len == LW'(MAX_SYM)) begin
                r_err_pend <= 1'b1;
            end else begin
                if (w_sym == SYM_DASH) r_pattern <= r_pattern | (MAX_SYM'(1) << r_len);
                r_len <= r_len + 1'b1;
            end
        end
    end

    // Single-entry holding register; a token arriving while it is stuck is lost.
    logic w_emit, w_accept;

    assign w_emit   = w_emit_letter | w_emit_space;
    assign w_accept = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pattern <= '0;
            out_len     <= '0;
            out_space   <= 1'b0;
            out_err     <= 1'b0;
            ovf         <= 1'b0;
        end else if (w_emit) begin
            if (!out_valid || w_accept) begin
                out_valid   <= 1'b1;
                out_pattern <= w_emit_space ? '0 : r_pattern;
                out_len     <= w_emit_space ? '0 : r_len;
                out_space   <= w_emit_space;
                out_err     <= w_emit_space ? 1'b0 : r_err_pend;
            end else begin
                ovf <= 1'b1;
            end
        end else if (w_accept) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_morse_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_key_decoder
// Description : Scoreboard bench for morse_key_decoder with TICK_DIV=10.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_morse_key_decoder;

    localparam int TICK_DIV = 10;
    localparam int MAX_SYM  = 6;
    localparam int LW       = $clog2(MAX_SYM + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               key = 1'b0;
    logic [2:0]         speed_sel = 3'd7;
    logic               is_active = 1'b1;
    logic               out_ready = 1'b1;
    logic               out_valid, out_space, out_err, ovf, key_led;
    logic [MAX_SYM-1:0] out_pattern;
    logic [LW-1:0]      out_len;

    typedef struct packed {
        logic [MAX_SYM-1:0] pattern;
        logic [LW-1:0]      len;
        logic               space;
        logic               err;
    } tok_t;

    tok_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    morse_key_decoder #(
        .TICK_DIV (TICK_DIV),
        .MAX_SYM  (MAX_SYM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .speed_sel   (speed_sel),
        .is_active   (is_active),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pattern (out_pattern),
        .out_len     (out_len),
        .out_space   (out_space),
        .out_err     (out_err),
        .ovf         (ovf),
        .key_led     (key_led)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int ms);
        key = 1'b1;
        cyc(ms * TICK_DIV);
        key = 1'b0;
    endtask

    task automatic gap(input int ms);
        cyc(ms * TICK_DIV);
    endtask

    task automatic push(input logic [MAX_SYM-1:0] p, input int l, input logic s, input logic e);
        tok_t t;
        t.pattern = p;
        t.len     = LW'(l);
        t.space   = s;
        t.err     = e;
        exp_q.push_back(t);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 2000;
        while (exp_q.size() != 0 && budget > 0) begin
            cyc(1);
            budget--;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every accepted token is compared against the head of the queue.
    initial begin
        tok_t a, e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                a = {out_pattern, out_len, out_space, out_err};
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_token: got %0h expected none", a);
                end else begin
                    e = exp_q.pop_front();
                    check("token", 32'(a), 32'(e));
                end
            end
        end
    end

    initial begin
        cyc(5);
        rst = 1'b0;
        cyc(3);
        @(negedge clk);
        check("rst_valid",   32'(out_valid),   32'd0);
        check("rst_pattern", 32'(out_pattern), 32'd0);
        check("rst_len",     32'(out_len),     32'd0);
        check("rst_space",   32'(out_space),   32'd0);
        check("rst_err",     32'(out_err),     32'd0);
        check("rst_ovf",     32'(ovf),         32'd0);
        check("rst_key_led", 32'(key_led),     32'd0);
        cyc(1);

        // "A" then a word space
        push(6'b000010, 2, 1'b0, 1'b0);
        push(6'b000000, 0, 1'b1, 1'b0);
        press(20); gap(20); press(60); gap(80);
        gap(100);
        drain("drain_A");

        // Seven dots overflow the symbol buffer
        push(6'b000000, 6, 1'b0, 1'b1);
        push(6'b000000, 0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            press(20);
            if (i < 6) gap(20);
        end
        gap(80);
        gap(100);
        drain("drain_err");

        // Consumer stalled across two letters: "E" held, "T" dropped
        out_ready = 1'b0;
        push(6'b000000, 1, 1'b0, 1'b0);
        push(6'b000000, 0, 1'b1, 1'b0);
        press(20); gap(80);
        press(60); gap(80);
        @(negedge clk);
        check("hold_valid",   32'(out_valid),   32'd1);
        check("hold_len",     32'(out_len),     32'd1);
        check("hold_pattern", 32'(out_pattern), 32'd0);
        check("hold_space",   32'(out_space),   32'd0);
        check("hold_ovf",     32'(ovf),         32'd1);
        cyc(1);
        out_ready = 1'b1;
        gap(100);
        drain("drain_ovf");

        // Speed change mid-press applies from the next press
        push(6'b000001, 2, 1'b0, 1'b0);
        push(6'b000000, 0, 1'b1, 1'b0);
        key = 1'b1;
        cyc(10 * TICK_DIV);
        speed_sel = 3'd0;
        cyc(50 * TICK_DIV);
        key = 1'b0;
        gap(20);
        press(200);
        gap(500);
        gap(700);
        drain("drain_speed");
        speed_sel = 3'd7;

        // Reset during a press with three symbols buffered
        for (int i = 0; i < 3; i++) begin
            press(20); gap(20);
        end
        key = 1'b1;
        cyc(10 * TICK_DIV);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid",   32'(out_valid),   32'd0);
        check("mid_rst_len",     32'(out_len),     32'd0);
        check("mid_rst_pattern", 32'(out_pattern), 32'd0);
        check("mid_rst_ovf",     32'(ovf),         32'd0);
        check("mid_rst_key_led", 32'(key_led),     32'd0);
        cyc(1);
        key = 1'b0;
        cyc(5);
        rst = 1'b0;
        gap(300);
        check("post_rst_idle", 32'(out_valid), 32'd0);
        check("queue_empty",   32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
